// File: rtl/ram_fifo_ctrl.sv
// Ready/valid FIFO controller sequencing an external ram_1r1w_sync as storage;
// the RAM output register holds the head entry. Optional sticky overflow flag: RAM_FIFO_OVERFLOW_EN.
module ram_fifo_ctrl #(
  parameter  int width_p = 8,
  parameter  int depth_p = 32,
  localparam int ptr_w   = $clog2(depth_p),
  localparam int rc_w    = $clog2(depth_p + 1),
  localparam int cnt_w   = $clog2(depth_p + 1) + 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i,
  output logic [cnt_w-1:0]   count_o,
  output logic               ram_wr_valid_o,
  output logic [ptr_w-1:0]   ram_wr_addr_o,
  output logic [width_p-1:0] ram_wr_data_o,
  output logic               ram_rd_valid_o,
  output logic [ptr_w-1:0]   ram_rd_addr_o,
  input  logic [width_p-1:0] ram_rd_data_i,
  output logic               overflow_o
);

  localparam logic [rc_w-1:0] ram_full_c = rc_w'(depth_p);

  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [rc_w-1:0]  ram_count_q, ram_count_d;
  logic             head_valid_q, head_valid_d;

  logic push;
  logic pop;
  logic issue;

  // Flow control depends only on registered state, never on valid_i/ready_i.
  assign ready_o = (ram_count_q != ram_full_c);
  assign valid_o = head_valid_q;
  assign data_o  = ram_rd_data_i;
  assign count_o = cnt_w'(ram_count_q) + cnt_w'(head_valid_q);

  // Strobes are gated by reset so the RAM sees no access while state is being cleared.
  // A same-cycle push is not yet in ram_count, so a read never targets the address being written.
  assign push  = valid_i & ready_o & ~reset_i;
  assign pop   = head_valid_q & ready_i;
  assign issue = (ram_count_q != '0) & (~head_valid_q | pop) & ~reset_i;

  assign ram_wr_valid_o = push;
  assign ram_wr_addr_o  = wr_ptr_q;
  assign ram_wr_data_o  = data_i;
  assign ram_rd_valid_o = issue;
  assign ram_rd_addr_o  = rd_ptr_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ram_count_d  = ram_count_q;
    head_valid_d = issue | (head_valid_q & ~pop);

    if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (issue) rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, issue})
      2'b10:   ram_count_d = ram_count_q + rc_w'(1);
      2'b01:   ram_count_d = ram_count_q - rc_w'(1);
      default: ram_count_d = ram_count_q;
    endcase
  end

  // NOTE: only control state is reset; the RAM array is external and keeps its contents,
  // which is harmless because nothing is read before it has been written.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_count_q  <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      head_valid_q <= head_valid_d;
    end
  end

`ifdef RAM_FIFO_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // Sticky: a refused push drops its data and flags it until the next reset.
  assign overflow_d = overflow_q | (valid_i & ~ready_o);
  assign overflow_o = overflow_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) overflow_q <= 1'b0;
    else         overflow_q <= overflow_d;
  end
`else
  assign overflow_o = 1'b0;
`endif

endmodule
